adder_tree_accumulator: RTL and testbench
=========================================

Name: adder_tree_accumulator

Overview:
- Downstream stage for the adder-tree benchmark modules: consumes one signed partial sum per beat (the adder tree's `sum_out`) over a valid/ready handshake.
- Accumulates a run-time-configurable number of beats into a wider accumulator.
- Presents one result per group through a registered valid/ready output with an overflow flag.
- Used to chain adder trees into long dot-product reductions in proxy benchmarks.

Parameters:
- IN_W, 32, width of incoming signed partial sum.
- ACC_W, 40, accumulator/result width; must be >= IN_W.
- CNT_W, 8, width of beat counter and cfg_len.

Ports:
- clk  input  1  clock; all state on rising edge.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- cfg_len  input  CNT_W  beats per group; sampled only on the first beat of a group; 0 treated as 1.
- in_valid  input  1  in_data valid.
- in_ready  output  1  block accepts a beat this cycle.
- in_data  input  IN_W  signed partial sum.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts result.
- out_data  output  ACC_W  signed accumulated result.
- out_ovf  output  1  overflow occurred within this group; valid with out_data.
- busy  output  1  group in progress or result pending (state != IDLE).

Behaviour:
- Reset (reset=0, async):
  - state=IDLE; acc, cnt, len_q, out_data = 0; out_valid=0, out_ovf=0, busy=0.
  - in_ready forced 0 while reset is low.
  - Reset mid-group discards the partial group; no result is emitted.
- Beat accepted = in_valid && in_ready.
- States:
  - IDLE: in_ready=1. On a beat: len_q = max(cfg_len, 1); acc = sext(in_data); cnt=1; ovf=0. If len_q==1, go to HOLD, else ACCUM.
  - ACCUM: in_ready=1. On a beat: acc = acc + sext(in_data); cnt = cnt+1. When the new cnt == len_q, go to HOLD. No beat means hold all state (bubbles allowed).
  - HOLD: out_valid=1; out_data and out_ovf are stable, driven from registers; in_ready = out_ready (combinational).
    - On out_valid && out_ready with no beat: go to IDLE, out_valid=0 next cycle.
    - With a simultaneous beat: that beat starts a new group exactly as in IDLE (cfg_len re-sampled), giving back-to-back groups with no bubble.
- Latency: out_valid rises the cycle after the final beat is accepted.
- Sustained throughput with out_ready=1: one beat per cycle; one result every len cycles.
- Arithmetic: two's-complement, ACC_W-bit.
  - Overflow = operands of equal sign and sum of differing sign.
  - The overflow flag is sticky for the group; it is copied to out_ovf when entering HOLD.
  - Default behaviour (feature off): wrap modulo 2^ACC_W.
- cfg_len changes mid-group are ignored.
- cnt never exceeds len_q. len_q = 2^CNT_W - 1 is legal.
- out_data and out_ovf hold their last value after the handshake until the next result.

Optional Feature:
- Macro: ADDER_TREE_ACC_SATURATE_EN.
- Defined: on overflow, acc clamps to +(2^(ACC_W-1) - 1) or -2^(ACC_W-1) according to the operand sign. Clamping stays saturated for subsequent same-direction beats and may recover on opposite-sign beats. out_ovf is still set.
- Undefined: wraps as above; no saturation logic is synthesized.

Test Plan:
- Reset then basic group: cfg_len=4, beats 10, -3, 7, 100, out_ready=1 -> out_valid one cycle after the 4th beat; out_data=114; out_ovf=0; in_ready=1 throughout.
- Back-to-back with backpressure: cfg_len=2, beats 5, 6 -> result 11 held while out_ready=0 for 3 cycles, with in_ready=0 and data stable. Then out_ready=1 together with in_valid beat 1, followed by beat 2 -> 11 accepted, next result=3, no lost beat.
- cfg_len=0 and cfg_len=1: single beat -1234 -> out_data=-1234 next cycle. A cfg_len change from 3 to 1 mid-group is ignored, so the group still takes 3 beats.
- Overflow, ACC_W=40 with IN_W=32: 300 beats is illegal with CNT_W=8, so use 255 beats of 0x7FFFFFFF -> out_data=255*(2^31-1), out_ovf=0. Repeat with ACC_W=34 -> out_ovf=1; wrapped value without the macro, 0x1FFFFFFFF with ADDER_TREE_ACC_SATURATE_EN.
- Async reset mid-group: assert reset=0 between clock edges after 2 of 4 beats -> out_valid, busy and in_ready go to 0 immediately. After release, a fresh 4-beat group of 1s -> out_data=4.
- Bubbles: cfg_len=3, in_valid toggling 1,0,0,1,0,1 with data 2,x,x,4,x,8 -> out_data=14; idle cycles do not change acc or cnt.

Source files
------------

// File: rtl/adder_tree_accumulator_if.sv
// Valid/ready bundle for the adder-tree accumulator.
// Upstream beats plus config enter; grouped results leave.
interface adder_tree_accumulator_if #(
  parameter int IN_W  = 32,
  parameter int ACC_W = 40,
  parameter int CNT_W = 8
);
  logic [CNT_W-1:0]        cfg_len;
  logic                    in_valid;
  logic                    in_ready;
  logic signed [IN_W-1:0]  in_data;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [ACC_W-1:0] out_data;
  logic                    out_ovf;
  logic                    busy;

  modport master (
    output cfg_len, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_ovf, busy
  );

  modport slave (
    input  cfg_len, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_ovf, busy
  );
endinterface

// File: rtl/adder_tree_accumulator.sv
// Accumulates cfg_len signed beats per group into an ACC_W result.
// Define ADDER_TREE_ACC_SATURATE_EN to clamp instead of wrap.
module adder_tree_accumulator #(
  parameter int IN_W  = 32,
  parameter int ACC_W = 40,
  parameter int CNT_W = 8
) (
  input logic clk,
  input logic reset,
  adder_tree_accumulator_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    HOLD
  } state_t;

  state_t                  state;
  logic signed [ACC_W-1:0] acc;
  logic [CNT_W-1:0]        cnt;
  logic [CNT_W-1:0]        len_q;
  logic                    ovf;
  logic signed [ACC_W-1:0] data_q;
  logic                    ovf_q;

  logic                    beat;
  logic signed [ACC_W-1:0] ext;
  logic signed [ACC_W-1:0] sum;
  logic signed [ACC_W-1:0] acc_add;
  logic                    add_ovf;
  logic                    ovf_nx;
  logic [CNT_W-1:0]        cnt_nx;
  logic [CNT_W-1:0]        len_in;

  assign bus.in_ready  = reset &&
                         ((state != HOLD) || bus.out_ready);
  assign bus.out_valid = (state == HOLD);
  assign bus.busy      = (state != IDLE);
  assign bus.out_data  = data_q;
  assign bus.out_ovf   = ovf_q;

  assign beat   = bus.in_valid && bus.in_ready;
  assign ext    = ACC_W'(bus.in_data);
  assign sum    = acc + ext;
  assign cnt_nx = cnt + CNT_W'(1);
  assign ovf_nx = ovf | add_ovf;
  assign len_in = (bus.cfg_len == '0) ? CNT_W'(1)
                                      : bus.cfg_len;

  // Same-sign operands whose sum flips sign.
  assign add_ovf = (acc[ACC_W-1] == ext[ACC_W-1]) &&
                   (sum[ACC_W-1] != acc[ACC_W-1]);

`ifdef ADDER_TREE_ACC_SATURATE_EN
  localparam logic signed [ACC_W-1:0] MAXV =
    {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] MINV =
    {1'b1, {(ACC_W-1){1'b0}}};

  assign acc_add = !add_ovf      ? sum  :
                   acc[ACC_W-1]  ? MINV : MAXV;
`else
  assign acc_add = sum;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      acc    <= '0;
      cnt    <= '0;
      len_q  <= '0;
      ovf    <= 1'b0;
      data_q <= '0;
      ovf_q  <= 1'b0;
    end else if (beat) begin
      if (state == ACCUM) begin
        acc <= acc_add;
        cnt <= cnt_nx;
        ovf <= ovf_nx;
        if (cnt_nx == len_q) begin
          state  <= HOLD;
          data_q <= acc_add;
          ovf_q  <= ovf_nx;
        end
      end else begin
        // IDLE, or HOLD draining while a new group starts
        acc   <= ext;
        cnt   <= CNT_W'(1);
        len_q <= len_in;
        ovf   <= 1'b0;
        if (len_in == CNT_W'(1)) begin
          state  <= HOLD;
          data_q <= ext;
          ovf_q  <= 1'b0;
        end else begin
          state <= ACCUM;
        end
      end
    end else if (state == HOLD && bus.out_ready) begin
      state <= IDLE;
    end
  end

endmodule

// File: tb/tb_adder_tree_accumulator.sv
// Directed bench for adder_tree_accumulator.
// Second instance uses ACC_W=34 to force overflow.
module tb_adder_tree_accumulator;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  adder_tree_accumulator_if #(.IN_W(32), .ACC_W(40), .CNT_W(8)) b0 ();
  adder_tree_accumulator_if #(.IN_W(32), .ACC_W(34), .CNT_W(8)) b1 ();

  adder_tree_accumulator #(.IN_W(32), .ACC_W(40), .CNT_W(8)) u0 (
    .clk(clk), .reset(reset), .bus(b0.slave)
  );

  adder_tree_accumulator #(.IN_W(32), .ACC_W(34), .CNT_W(8)) u1 (
    .clk(clk), .reset(reset), .bus(b1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    tick();
    tick();
    checks++;
    if (b0.out_valid !== 1'b0 || b0.busy !== 1'b0 || b0.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctl got v=%b b=%b r=%b exp 0 0 0",
               b0.out_valid, b0.busy, b0.in_ready);
    end
    checks++;
    if (b0.out_data !== 40'sd0 || b0.out_ovf !== 1'b0) begin
      errors++;
      $display("FAIL reset_data got %0d ovf=%b exp 0 0", b0.out_data, b0.out_ovf);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (b0.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready got %b exp 1", b0.in_ready);
    end
    tick();
  endtask

  task automatic test_basic();
    logic signed [31:0] v [4];
    v[0] = 10; v[1] = -3; v[2] = 7; v[3] = 100;
    b0.cfg_len   = 8'd4;
    b0.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      b0.in_valid = 1'b1;
      b0.in_data  = v[i];
      #1;
      checks++;
      if (b0.in_ready !== 1'b1 || b0.out_valid !== 1'b0) begin
        errors++;
        $display("FAIL basic_beat%0d got r=%b v=%b exp 1 0",
                 i, b0.in_ready, b0.out_valid);
      end
      tick();
    end
    b0.in_valid = 1'b0;
    checks++;
    if (b0.out_valid !== 1'b1 || b0.out_data !== 40'sd114 || b0.out_ovf !== 1'b0) begin
      errors++;
      $display("FAIL basic_result got v=%b d=%0d o=%b exp 1 114 0",
               b0.out_valid, b0.out_data, b0.out_ovf);
    end
    tick();
    checks++;
    if (b0.out_valid !== 1'b0 || b0.busy !== 1'b0 || b0.out_data !== 40'sd114) begin
      errors++;
      $display("FAIL basic_idle got v=%b b=%b d=%0d exp 0 0 114",
               b0.out_valid, b0.busy, b0.out_data);
    end
  endtask

  task automatic test_back_to_back();
    b0.cfg_len   = 8'd2;
    b0.out_ready = 1'b0;
    b0.in_valid  = 1'b1;
    b0.in_data   = 32'sd5;
    tick();
    b0.in_data = 32'sd6;
    tick();
    // beat 1 of the next group waits under backpressure
    b0.in_data = 32'sd1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (b0.out_valid !== 1'b1 || b0.out_data !== 40'sd11 || b0.in_ready !== 1'b0) begin
        errors++;
        $display("FAIL b2b_hold%0d got v=%b d=%0d r=%b exp 1 11 0",
                 i, b0.out_valid, b0.out_data, b0.in_ready);
      end
      tick();
    end
    b0.out_ready = 1'b1;
    #1;
    checks++;
    if (b0.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_release_ready got %b exp 1", b0.in_ready);
    end
    tick();
    checks++;
    if (b0.out_valid !== 1'b0 || b0.busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_newgroup got v=%b b=%b exp 0 1", b0.out_valid, b0.busy);
    end
    b0.in_data = 32'sd2;
    tick();
    b0.in_valid = 1'b0;
    checks++;
    if (b0.out_valid !== 1'b1 || b0.out_data !== 40'sd3) begin
      errors++;
      $display("FAIL b2b_second got v=%b d=%0d exp 1 3", b0.out_valid, b0.out_data);
    end
    tick();
  endtask

  task automatic test_len01();
    logic [7:0] lens [2];
    lens[0] = 8'd0;
    lens[1] = 8'd1;
    b0.out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      b0.cfg_len  = lens[i];
      b0.in_valid = 1'b1;
      b0.in_data  = -32'sd1234;
      tick();
      b0.in_valid = 1'b0;
      checks++;
      if (b0.out_valid !== 1'b1 || b0.out_data !== -40'sd1234) begin
        errors++;
        $display("FAIL len%0d_result got v=%b d=%0d exp 1 -1234",
                 lens[i], b0.out_valid, b0.out_data);
      end
      tick();
    end
    b0.cfg_len  = 8'd3;
    b0.in_valid = 1'b1;
    b0.in_data  = 32'sd1;
    tick();
    b0.cfg_len = 8'd1;
    b0.in_data = 32'sd2;
    tick();
    checks++;
    if (b0.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL len_change_early got v=%b exp 0", b0.out_valid);
    end
    b0.in_data = 32'sd3;
    tick();
    b0.in_valid = 1'b0;
    checks++;
    if (b0.out_valid !== 1'b1 || b0.out_data !== 40'sd6) begin
      errors++;
      $display("FAIL len_change_result got v=%b d=%0d exp 1 6",
               b0.out_valid, b0.out_data);
    end
    tick();
  endtask

  task automatic test_bubbles();
    logic vld [6];
    logic signed [31:0] dat [6];
    vld[0] = 1; vld[1] = 0; vld[2] = 0; vld[3] = 1; vld[4] = 0; vld[5] = 1;
    dat[0] = 2; dat[1] = 77; dat[2] = -9; dat[3] = 4; dat[4] = 55; dat[5] = 8;
    b0.cfg_len   = 8'd3;
    b0.out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      b0.in_valid = vld[i];
      b0.in_data  = dat[i];
      tick();
      if (i < 5) begin
        checks++;
        if (b0.out_valid !== 1'b0 || b0.busy !== 1'b1) begin
          errors++;
          $display("FAIL bubble_step%0d got v=%b b=%b exp 0 1",
                   i, b0.out_valid, b0.busy);
        end
      end
    end
    b0.in_valid = 1'b0;
    checks++;
    if (b0.out_valid !== 1'b1 || b0.out_data !== 40'sd14) begin
      errors++;
      $display("FAIL bubble_result got v=%b d=%0d exp 1 14",
               b0.out_valid, b0.out_data);
    end
    tick();
  endtask

  task automatic test_async_reset();
    b0.cfg_len   = 8'd4;
    b0.out_ready = 1'b1;
    b0.in_valid  = 1'b1;
    b0.in_data   = 32'sd1;
    tick();
    tick();
    b0.in_valid = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (b0.out_valid !== 1'b0 || b0.busy !== 1'b0 || b0.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL areset_now got v=%b b=%b r=%b exp 0 0 0",
               b0.out_valid, b0.busy, b0.in_ready);
    end
    tick();
    reset = 1'b1;
    b0.in_valid = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    b0.in_valid = 1'b0;
    checks++;
    if (b0.out_valid !== 1'b1 || b0.out_data !== 40'sd4 || b0.out_ovf !== 1'b0) begin
      errors++;
      $display("FAIL areset_fresh got v=%b d=%0d o=%b exp 1 4 0",
               b0.out_valid, b0.out_data, b0.out_ovf);
    end
    tick();
  endtask

  task automatic test_overflow();
    logic [33:0] exp1;
`ifdef ADDER_TREE_ACC_SATURATE_EN
    exp1 = 34'h1FFFFFFFF;
`else
    exp1 = 34'h37FFFFF01;
`endif
    b0.cfg_len   = 8'd255;
    b1.cfg_len   = 8'd255;
    b0.out_ready = 1'b1;
    b1.out_ready = 1'b1;
    b0.in_data   = 32'sh7FFFFFFF;
    b1.in_data   = 32'sh7FFFFFFF;
    b0.in_valid  = 1'b1;
    b1.in_valid  = 1'b1;
    for (int i = 0; i < 254; i++) tick();
    checks++;
    if (b0.out_valid !== 1'b0 || b1.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL ovf_early got v0=%b v1=%b exp 0 0", b0.out_valid, b1.out_valid);
    end
    tick();
    b0.in_valid = 1'b0;
    b1.in_valid = 1'b0;
    checks++;
    if (b0.out_valid !== 1'b1 || b0.out_data !== 40'sh7F7FFFFF01 || b0.out_ovf !== 1'b0) begin
      errors++;
      $display("FAIL ovf_wide got v=%b d=%h o=%b exp 1 7f7fffff01 0",
               b0.out_valid, b0.out_data, b0.out_ovf);
    end
    checks++;
    if (b1.out_valid !== 1'b1 || b1.out_data !== exp1 || b1.out_ovf !== 1'b1) begin
      errors++;
      $display("FAIL ovf_narrow got v=%b d=%h o=%b exp 1 %h 1",
               b1.out_valid, b1.out_data, b1.out_ovf, exp1);
    end
    tick();
    checks++;
    if (b1.out_valid !== 1'b0 || b1.out_ovf !== 1'b1 || b1.out_data !== exp1) begin
      errors++;
      $display("FAIL ovf_hold_after got v=%b d=%h o=%b exp 0 %h 1",
               b1.out_valid, b1.out_data, b1.out_ovf, exp1);
    end
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    reset        = 1'b0;
    b0.cfg_len   = '0;
    b0.in_valid  = 1'b0;
    b0.in_data   = '0;
    b0.out_ready = 1'b1;
    b1.cfg_len   = '0;
    b1.in_valid  = 1'b0;
    b1.in_data   = '0;
    b1.out_ready = 1'b1;
    test_reset();
    test_basic();
    test_back_to_back();
    test_len01();
    test_bubbles();
    test_async_reset();
    test_overflow();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
